// File: rtl/tgc_pkg.sv
// Shared FSM state encoding and parameter defaults for the traffic generator/checker.
package tgc_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WRITE   = 3'd1,
    S_WAIT_WR = 3'd2,
    S_READ    = 3'd3,
    S_DRAIN   = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  localparam int DEF_DATA_WIDTH   = 16;
  localparam int DEF_ADDR_WIDTH   = 30;
  localparam int DEF_NUM_REQ      = 1024;
  localparam int DEF_IDLE_TIMEOUT = 200;

endpackage

// File: rtl/tgc_compare.sv
// In-order read-return checker: compares returns against the expected pattern,
// counts mismatches and spurious returns, and latches the first failing address.
module tgc_compare
  import tgc_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_REQ    = DEF_NUM_REQ
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             clear,
  input  logic                             check_en,
  input  logic                             spurious_en,
  input  logic                             read_done,
  input  logic [DATA_WIDTH-1:0]            data_out,
  output logic [$clog2(NUM_REQ+1)-1:0]     ret_cnt,
  output logic [15:0]                      error_count,
  output logic [ADDR_WIDTH-1:0]            first_err_addr
);

  localparam int CW = $clog2(NUM_REQ + 1);
  localparam logic [CW-1:0] FULL = CW'(NUM_REQ);

  logic [DATA_WIDTH-1:0] exp_data;
  logic                  in_range;
  logic                  err_now;

  // A return beyond NUM_REQ has no expected value, so it is an error and does not advance.
  assign exp_data = DATA_WIDTH'(ret_cnt);
  assign in_range = (ret_cnt != FULL);
  assign err_now  = read_done &
                    (spurious_en | (check_en & (~in_range | (data_out != exp_data))));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ret_cnt        <= '0;
      error_count    <= '0;
      first_err_addr <= '0;
    end else if (clear) begin
      ret_cnt        <= '0;
      error_count    <= '0;
      first_err_addr <= '0;
    end else begin
      if (read_done && check_en && in_range) ret_cnt <= ret_cnt + CW'(1);
      if (err_now) begin
        if (error_count != 16'hFFFF) error_count <= error_count + 16'd1;
        if (error_count == 16'd0) first_err_addr <= ADDR_WIDTH'(ret_cnt);
      end
    end
  end

endmodule

// File: rtl/traffic_gen_checker.sv
// Memory-controller exerciser: writes an address-indexed pattern, reads it back,
// and reports mismatches, spurious returns, idle timeout and run length.
module traffic_gen_checker
  import tgc_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int NUM_REQ      = DEF_NUM_REQ,
  parameter int IDLE_TIMEOUT = DEF_IDLE_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  out_busy,
  output logic                  in_valid,
  output logic                  in_request_type,
  output logic [ADDR_WIDTH-1:0] in_request_address,
  output logic [DATA_WIDTH-1:0] in_request_data,
  input  logic                  write_done,
  input  logic                  read_done,
  input  logic [DATA_WIDTH-1:0] data_out,
  output logic                  done,
  output logic                  pass,
  output logic                  timeout,
  output logic [15:0]           error_count,
  output logic [ADDR_WIDTH-1:0] first_err_addr,
  output logic [31:0]           run_cycles,
  output logic [2:0]            fsm_state
);

  localparam int CW = $clog2(NUM_REQ + 1);
  localparam int TW = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [CW-1:0] LAST      = CW'(NUM_REQ - 1);
  localparam logic [CW-1:0] FULL      = CW'(NUM_REQ);
  localparam logic [TW-1:0] IDLE_LAST = TW'(IDLE_TIMEOUT - 1);

  state_t        state;
  logic [CW-1:0] iss_cnt, iss_next, wr_cnt, ret_cnt;
  logic [TW-1:0] idle_cnt;
  logic          accept, launch, active, idle_expire;

  // Handshake: a request transfers on a rising edge with in_valid=1 and out_busy=0;
  // while out_busy=1 the request fields hold, and the next request follows an
  // acceptance in the very next cycle.
  assign accept      = in_valid & ~out_busy;
  assign launch      = start & ((state == S_IDLE) | (state == S_DONE));
  assign active      = (state != S_IDLE) & (state != S_DONE);
  assign iss_next    = iss_cnt + CW'(1);
  assign idle_expire = ~read_done & (idle_cnt == IDLE_LAST);
  assign pass        = done & (error_count == 16'd0) & ~timeout;
  assign fsm_state   = state;

  tgc_compare #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_REQ    (NUM_REQ)
  ) u_compare (
    .clk            (clk),
    .rst            (rst),
    .clear          (launch),
    .check_en       ((state == S_READ) | (state == S_DRAIN)),
    .spurious_en    ((state == S_IDLE) | (state == S_WRITE) | (state == S_WAIT_WR)),
    .read_done      (read_done),
    .data_out       (data_out),
    .ret_cnt        (ret_cnt),
    .error_count    (error_count),
    .first_err_addr (first_err_addr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state              <= S_IDLE;
      in_valid           <= 1'b0;
      in_request_type    <= 1'b0;
      in_request_address <= '0;
      in_request_data    <= '0;
      iss_cnt            <= '0;
      wr_cnt             <= '0;
      idle_cnt           <= '0;
      done               <= 1'b0;
      timeout            <= 1'b0;
      run_cycles         <= '0;
    end else begin
      if (write_done && state != S_IDLE && wr_cnt != FULL) wr_cnt <= wr_cnt + CW'(1);
      if (active && run_cycles != 32'hFFFF_FFFF) run_cycles <= run_cycles + 32'd1;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state              <= S_WRITE;
            in_valid           <= 1'b1;
            in_request_type    <= 1'b1;
            in_request_address <= '0;
            in_request_data    <= '0;
            iss_cnt            <= '0;
            wr_cnt             <= '0;
            idle_cnt           <= '0;
            done               <= 1'b0;
            timeout            <= 1'b0;
            run_cycles         <= '0;
          end
        end
        S_WRITE: begin
          if (accept) begin
            if (iss_cnt == LAST) begin
              state              <= S_WAIT_WR;
              in_valid           <= 1'b0;
              in_request_type    <= 1'b0;
              in_request_address <= '0;
              in_request_data    <= '0;
            end else begin
              iss_cnt            <= iss_next;
              in_request_address <= ADDR_WIDTH'(iss_next);
              in_request_data    <= DATA_WIDTH'(iss_next);
            end
          end
        end
        S_WAIT_WR: begin
          if (wr_cnt == FULL) begin
            state    <= S_READ;
            in_valid <= 1'b1;
            iss_cnt  <= '0;
            idle_cnt <= '0;
          end
        end
        S_READ: begin
          if (accept) begin
            if (iss_cnt == LAST) begin
              state              <= S_DRAIN;
              in_valid           <= 1'b0;
              in_request_address <= '0;
            end else begin
              iss_cnt            <= iss_next;
              in_request_address <= ADDR_WIDTH'(iss_next);
            end
          end
          if (read_done) idle_cnt <= '0;
          else if (idle_expire) begin
            state    <= S_DONE;
            done     <= 1'b1;
            timeout  <= 1'b1;
            in_valid <= 1'b0;
          end else idle_cnt <= idle_cnt + TW'(1);
        end
        S_DRAIN: begin
          if (ret_cnt == FULL) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else if (read_done) idle_cnt <= '0;
          else if (idle_expire) begin
            state   <= S_DONE;
            done    <= 1'b1;
            timeout <= 1'b1;
          end else idle_cnt <= idle_cnt + TW'(1);
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/traffic_gen_checker.md
TRAFFIC_GEN_CHECKER -- requirements
Module: traffic_gen_checker

Interface
REQ-001 Parameter DATA_WIDTH, default 16: width of the request data and read-return data.
REQ-002 Parameter ADDR_WIDTH, default 30: width of the request address.
REQ-003 Parameter NUM_REQ, default 1024: number of writes, then reads, per run (2..65535).
REQ-004 Parameter IDLE_TIMEOUT, default 200: maximum idle cycles between read returns before the run is aborted.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 start  in  1  single-cycle pulse that starts a run.
REQ-008 out_busy  in  1  controller cannot accept a request this cycle.
REQ-009 in_valid  out  1  request valid to the controller.
REQ-010 in_request_type  out  1  1 = write, 0 = read.
REQ-011 in_request_address  out  ADDR_WIDTH  request address.
REQ-012 in_request_data  out  DATA_WIDTH  write data.
REQ-013 write_done  in  1  one-cycle pulse per completed write.
REQ-014 read_done  in  1  one-cycle pulse per returned read, with data_out valid in that cycle.
REQ-015 data_out  in  DATA_WIDTH  read-return data.
REQ-016 done  out  1  run finished; held until the next start or reset.
REQ-017 pass  out  1  valid while done; 1 = zero errors and no timeout.
REQ-018 timeout  out  1  run aborted by the idle timeout.
REQ-019 error_count  out  16  mismatches plus spurious returns; saturates at 16'hFFFF.
REQ-020 first_err_addr  out  ADDR_WIDTH  expected address of the first error.
REQ-021 run_cycles  out  32  cycles from start to done; saturating.

Function
REQ-022 The FSM SHALL have the states IDLE, WRITE, WAIT_WR, READ, DRAIN and DONE.
REQ-023 IDLE or DONE + start: the FSM SHALL clear all counters and status outputs and go to WRITE; start is ignored in every other state.
REQ-024 Handshake: a request is accepted on a rising edge where in_valid=1 and out_busy=0.
  - type, address and data SHALL be held stable while in_valid=1 and out_busy=1.
  - After an acceptance, the next request SHALL be presented in the following cycle (back-to-back; no bubble required).
REQ-025 WRITE: the k-th write (k = 0..NUM_REQ-1) SHALL use address k (zero-extended) and data k[DATA_WIDTH-1:0].
  - After acceptance of write NUM_REQ-1: in_valid is deasserted and the FSM goes to WAIT_WR.
REQ-026 The write_done counter SHALL count write_done in every non-IDLE state, including pulses that arrive during WRITE.
  - WAIT_WR goes to READ in the cycle after the count reaches NUM_REQ.
REQ-027 READ: the k-th read SHALL use address k and type 0 (data don't-care, driven 0).
  - After acceptance of read NUM_REQ-1: the FSM goes to DRAIN.
REQ-028 Read returns are in order.
  - Each read_done in READ or DRAIN SHALL compare data_out against expected[DATA_WIDTH-1:0], then increment expected.
  - A mismatch increments error_count.
  - A read_done in IDLE, WRITE or WAIT_WR SHALL increment error_count (spurious return).
REQ-029 first_err_addr SHALL latch the expected address of the first error only; later errors leave it unchanged.
REQ-030 DRAIN: reaching NUM_REQ returns SHALL go to DONE.
  - The idle counter clears on each read_done and increments otherwise in READ and DRAIN.
  - Reaching IDLE_TIMEOUT SHALL go to DONE with timeout=1.
REQ-031 DONE: done=1; pass = (error_count==0 && !timeout); in_valid=0; read_done ignored.
REQ-032 A read_done in the same cycle as the final read acceptance SHALL be counted; simultaneous events never lose a count.
REQ-033 All counters SHALL be sized $clog2(NUM_REQ+1) and SHALL NOT wrap within a run.

Reset
REQ-034 rst SHALL force IDLE at any time, including mid-run, with every output 0: in_valid, in_request_type, in_request_address, in_request_data, done, pass, timeout, error_count, first_err_addr, run_cycles.
REQ-035 No request SHALL be presented in the first cycle after rst deasserts.

Structure
REQ-036 Package tgc_pkg SHALL hold the FSM state enum and the default values for DATA_WIDTH, ADDR_WIDTH, NUM_REQ and IDLE_TIMEOUT.
REQ-037 Compare, error counting and first-error latch SHALL live in the sub-module tgc_compare; the top holds the FSM, issue counters and timeout logic.

Verification
REQ-038 NUM_REQ=4, out_busy=0, ideal controller model -> 4 writes to addresses 0..3 with data 0..3, then 4 reads; done=1, pass=1, error_count=0.
REQ-039 out_busy=1 for 5 cycles during write 2 -> address=2 and data=2 held stable all 5 cycles; exactly 4 writes are accepted.
REQ-040 Model corrupts read 1 to 16'hDEAD -> error_count=1, first_err_addr=1, pass=0.
REQ-041 Model withholds the last read return -> done exactly 200 cycles after the last read_done, timeout=1, pass=0.
REQ-042 read_done pulsed during WRITE -> error_count=1; rst asserted mid-READ -> all outputs 0 and in_valid=0 in the same cycle.
REQ-043 start pulsed during READ -> ignored; start pulsed in DONE -> stats cleared and a new run begins at address 0.
